// File: rtl/dma_sync_fifo.sv
// Single-clock DMA channel FIFO: registered or first-word-fall-through read,
// registered fill level with thresholds, synchronous flush and sticky error flags.
module dma_sync_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr,
  input  logic [DATA_W-1:0]          w_data,
  input  logic                       rd,
  output logic [DATA_W-1:0]          r_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              wr_acc, rd_acc;

  // Handshake: wr/rd are requests with no separate ready; the registered
  // full/empty flags act as ready, so a request is accepted on the edge only
  // when its flag is clear at that edge, and flush drops both requests.
  assign wr_acc = wr & ~full_q  & ~flush;
  assign rd_acc = rd & ~empty_q & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    r_data_d = r_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    if ((FWFT == 0) && rd_acc) r_data_d = mem_q[rd_ptr_q[AW-1:0]];
    empty_d = (level_d == '0);
    full_d  = (level_d == PW'(DEPTH));
    af_d    = (level_d >= PW'(AF_LEVEL));
    ae_d    = (level_d <= PW'(AE_LEVEL));
    // A set event in the same cycle as clr_err wins over the clear.
    ovf_d   = (ovf_q & ~clr_err) | (wr & full_q  & ~flush);
    unf_d   = (unf_q & ~clr_err) | (rd & empty_q & ~flush);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      r_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      r_data_q <= r_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= w_data;
  end

  // In FWFT mode the head is shown directly; it is forced to zero while empty
  // so the output is defined out of reset.
  assign r_data = (FWFT != 0) ? (empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]]) : r_data_q;

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
